// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor: decodes the NS/EW light pair into a phase, checks order and dwell, counts cycles
// and keeps sticky error flags for the intersection watchdog.
module traffic_light_monitor #(
  parameter int GREEN_CYCLES  = 11,
  parameter int YELLOW_CYCLES = 4,
  parameter int DWELL_W       = 8,
  parameter int CNT_W         = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         ns_light,
  input  logic [1:0]         ew_light,
  input  logic               clr_err,
  output logic [1:0]         phase,
  output logic               locked,
  output logic [DWELL_W-1:0] dwell,
  output logic [CNT_W-1:0]   cycle_count,
  output logic               err_conflict,
  output logic               err_code,
  output logic               err_seq,
  output logic               err_timing,
  output logic               err_strobe
);
  typedef enum logic {ACQUIRE, TRACK} state_t;
  state_t state, state_nx;
  logic partial, partial_nx, conflict, legal, bad_code, tracking, same, succ;
  logic set_seq, set_tim, wrap;
  logic [1:0] q, phase_nx;
  logic [DWELL_W-1:0] exp_dw, dwell_nx;
  always_comb begin
    conflict = (ns_light != 2'b00) && (ew_light != 2'b00);
    legal    = {ns_light, ew_light} inside {4'b1000, 4'b0100, 4'b0010, 4'b0001};
    bad_code = !conflict && !legal;
    q        = ns_light == 2'b10 ? 2'd0 : ns_light == 2'b01 ? 2'd1 : ew_light == 2'b10 ? 2'd2 : 2'd3;
    exp_dw   = phase[0] ? DWELL_W'(YELLOW_CYCLES) : DWELL_W'(GREEN_CYCLES);
    tracking = state == TRACK && legal;
    same     = q == phase;
    succ     = q == phase + 2'd1;
    set_seq  = tracking && !same && !succ;
    // Partial phases were entered mid-dwell, so their length says nothing about the controller.
    set_tim  = tracking && !partial && (same ? dwell == exp_dw : succ && dwell < exp_dw);
    wrap     = tracking && succ && phase == 2'd3;
  end
  always_comb state_nx = legal ? TRACK : ACQUIRE;
  always_comb begin
    phase_nx   = legal ? q : phase;
    dwell_nx   = !legal ? '0 : (tracking && same) ? (&dwell ? dwell : dwell + DWELL_W'(1)) : DWELL_W'(1);
    partial_nx = !legal ? partial : (tracking && !set_seq) ? (same && partial) : 1'b1;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= ACQUIRE;
    else state <= state_nx;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      phase        <= '0;
      locked       <= 1'b0;
      dwell        <= '0;
      partial      <= 1'b0;
      cycle_count  <= '0;
      err_conflict <= 1'b0;
      err_code     <= 1'b0;
      err_seq      <= 1'b0;
      err_timing   <= 1'b0;
      err_strobe   <= 1'b0;
    end else begin
      phase        <= phase_nx;
      locked       <= legal;
      dwell        <= dwell_nx;
      partial      <= partial_nx;
      cycle_count  <= wrap ? cycle_count + CNT_W'(1) : cycle_count;
      err_conflict <= conflict | (err_conflict & ~clr_err);
      err_code     <= bad_code | (err_code & ~clr_err);
      err_seq      <= set_seq | (err_seq & ~clr_err);
      err_timing   <= set_tim | (err_timing & ~clr_err);
      err_strobe   <= conflict | bad_code | set_seq | set_tim;
    end
endmodule

// File: tb/tb_traffic_light_monitor.sv
// tb_traffic_light_monitor: directed scenarios plus randomized light sequences checked against
// a rule-level reference model of the monitor.
module tb_traffic_light_monitor;
  logic clk = 0, reset = 0, clr_err = 0;
  logic [1:0] ns_light = 0, ew_light = 0;
  logic [1:0] phase;
  logic locked, err_conflict, err_code, err_seq, err_timing, err_strobe;
  logic [7:0] dwell;
  logic [15:0] cycle_count;
  logic [31:0] dut_vec;
  int passed = 0, total = 0;
  int m_phase, m_dwell, m_cnt;
  bit m_locked, m_partial, m_conf, m_code, m_seq, m_tim, m_strobe;

  traffic_light_monitor dut (
    .clk(clk), .reset(reset), .ns_light(ns_light), .ew_light(ew_light), .clr_err(clr_err),
    .phase(phase), .locked(locked), .dwell(dwell), .cycle_count(cycle_count),
    .err_conflict(err_conflict), .err_code(err_code), .err_seq(err_seq),
    .err_timing(err_timing), .err_strobe(err_strobe)
  );

  always #5 clk = ~clk;
  assign dut_vec = {phase, locked, dwell, cycle_count, err_conflict, err_code, err_seq, err_timing, err_strobe};

  function automatic logic [31:0] m_vec();
    return {2'(m_phase), m_locked, 8'(m_dwell), 16'(m_cnt), m_conf, m_code, m_seq, m_tim, m_strobe};
  endfunction

  function automatic logic [3:0] pat(input int p);
    logic [3:0] t [4] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
    return t[p];
  endfunction

  function automatic int expected_len(input int p);
    return (p % 2 == 0) ? 11 : 4;
  endfunction

  task automatic model_clear();
    m_phase = 0; m_dwell = 0; m_cnt = 0; m_locked = 0; m_partial = 0;
    m_conf = 0; m_code = 0; m_seq = 0; m_tim = 0; m_strobe = 0;
  endtask

  task automatic model_update(input logic [1:0] ns, input logic [1:0] ew, input logic clr);
    bit conf, code, s_seq, s_tim;
    int q;
    conf = ns != 0 && ew != 0;
    q = -1;
    for (int i = 0; i < 4; i++) if ({ns, ew} == pat(i)) q = i;
    code = !conf && q < 0;
    s_seq = 0; s_tim = 0;
    if (conf || code) begin
      m_locked = 0; m_dwell = 0;
    end else if (!m_locked) begin
      m_locked = 1; m_phase = q; m_dwell = 1; m_partial = 1;
    end else if (q == m_phase) begin
      if (!m_partial && m_dwell == expected_len(m_phase)) s_tim = 1;
      m_dwell = m_dwell < 255 ? m_dwell + 1 : 255;
    end else if (q != (m_phase + 1) % 4) begin
      s_seq = 1; m_phase = q; m_partial = 1; m_dwell = 1;
    end else begin
      if (!m_partial && m_dwell < expected_len(m_phase)) s_tim = 1;
      if (m_phase == 3) m_cnt = (m_cnt + 1) % 65536;
      m_phase = q; m_partial = 0; m_dwell = 1;
    end
    m_conf = conf | (m_conf & !clr);
    m_code = code | (m_code & !clr);
    m_seq  = s_seq | (m_seq & !clr);
    m_tim  = s_tim | (m_tim & !clr);
    m_strobe = conf | code | s_seq | s_tim;
  endtask

  task automatic step(input logic [3:0] p, input logic clr = 0);
    ns_light = p[3:2]; ew_light = p[1:0]; clr_err = clr;
    @(posedge clk);
    #1;
    model_update(p[3:2], p[1:0], clr);
    clr_err = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    @(negedge clk);
    reset = 0;
    model_clear();
  endtask

  task automatic test_reset();
    reset = 1;
    #3;
    total++;
    if (dut_vec !== 32'h0) $display("FAIL reset_state: got %h expected %h", dut_vec, 32'h0);
    else passed++;
    @(negedge clk);
    reset = 0;
    model_clear();
  endtask

  task automatic test_nominal();
    do_reset();
    for (int r = 0; r < 3; r++)
      for (int p = 0; p < 4; p++)
        for (int k = 0; k < expected_len(p); k++) begin
          step(pat(p));
          total++;
          if (dut_vec !== m_vec() || err_strobe !== 1'b0)
            $display("FAIL nominal r%0d p%0d k%0d: got %h expected %h", r, p, k, dut_vec, m_vec());
          else passed++;
        end
    step(pat(0));
    total++;
    if ({cycle_count, locked, err_conflict, err_code, err_seq, err_timing, err_strobe} !== {16'd3, 6'b100000})
      $display("FAIL nominal_end: got cnt=%0d locked=%b errs=%b%b%b%b%b expected cnt=3 locked=1 errs=00000",
               cycle_count, locked, err_conflict, err_code, err_seq, err_timing, err_strobe);
    else passed++;
  endtask

  task automatic test_conflict();
    do_reset();
    repeat (3) step(pat(0));
    step(4'b1010);
    total++;
    if ({err_conflict, err_strobe, locked} !== 3'b110 || dut_vec !== m_vec())
      $display("FAIL conflict_hit: got %h expected %h", dut_vec, m_vec());
    else passed++;
    step(pat(0));
    total++;
    if ({err_conflict, err_strobe, locked, dwell} !== {3'b101, 8'd1} || dut_vec !== m_vec())
      $display("FAIL conflict_relock: got %h expected %h", dut_vec, m_vec());
    else passed++;
  endtask

  task automatic test_skip();
    do_reset();
    repeat (11) step(pat(0));
    step(pat(2));
    total++;
    if ({err_seq, err_timing, phase, dwell} !== {2'b10, 2'd2, 8'd1} || dut_vec !== m_vec())
      $display("FAIL skip: got %h expected %h", dut_vec, m_vec());
    else passed++;
  endtask

  task automatic test_timing();
    do_reset();
    step(pat(3));
    repeat (9) step(pat(0));
    total++;
    if (err_timing !== 1'b0) $display("FAIL short_pre: got %b expected 0", err_timing);
    else passed++;
    step(pat(1));
    total++;
    if ({err_timing, err_strobe} !== 2'b11 || dut_vec !== m_vec())
      $display("FAIL short: got %h expected %h", dut_vec, m_vec());
    else passed++;
    do_reset();
    step(pat(0));
    for (int k = 0; k < 6; k++) begin
      step(pat(1));
      total++;
      if ({err_timing, err_strobe} !== {k >= 4, k == 4} || dut_vec !== m_vec())
        $display("FAIL overrun k%0d: got %h expected %h", k, dut_vec, m_vec());
      else passed++;
    end
  endtask

  task automatic test_code_clear();
    do_reset();
    repeat (2) step(pat(0));
    step(4'b1100);
    total++;
    if ({err_code, err_conflict, locked} !== 3'b100 || dut_vec !== m_vec())
      $display("FAIL code_11: got %h expected %h", dut_vec, m_vec());
    else passed++;
    step(pat(0), 1);
    total++;
    if ({err_code, err_strobe} !== 2'b00 || dut_vec !== m_vec())
      $display("FAIL clear: got %h expected %h", dut_vec, m_vec());
    else passed++;
    step(4'b1010, 1);
    total++;
    if ({err_conflict, err_strobe} !== 2'b11 || dut_vec !== m_vec())
      $display("FAIL clear_vs_set: got %h expected %h", dut_vec, m_vec());
    else passed++;
    step(4'b0000, 1);
    total++;
    if ({err_code, err_conflict} !== 2'b10 || dut_vec !== m_vec())
      $display("FAIL both_red: got %h expected %h", dut_vec, m_vec());
    else passed++;
    step(4'b1110, 1);
    total++;
    if ({err_code, err_conflict} !== 2'b01 || dut_vec !== m_vec())
      $display("FAIL conflict_priority: got %h expected %h", dut_vec, m_vec());
    else passed++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    repeat (5) step(pat(2));
    total++;
    if (dwell !== 8'd5) $display("FAIL mid_pre: got dwell %0d expected 5", dwell);
    else passed++;
    #2 reset = 1;
    #1;
    total++;
    if (dut_vec !== 32'h0) $display("FAIL mid_async: got %h expected %h", dut_vec, 32'h0);
    else passed++;
    @(negedge clk);
    reset = 0;
    model_clear();
    step(pat(2));
    total++;
    if ({locked, dwell, err_timing, err_strobe} !== {1'b1, 8'd1, 2'b00} || dut_vec !== m_vec())
      $display("FAIL mid_relock: got %h expected %h", dut_vec, m_vec());
    else passed++;
  endtask

  task automatic test_random();
    int p, len;
    do_reset();
    p = 0;
    for (int seg = 0; seg < 60; seg++) begin
      p = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : (p + 1) % 4;
      len = $urandom_range(expected_len(p) - 1, expected_len(p) + 1);
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 24) == 0) step(4'($urandom_range(0, 15)), $urandom_range(0, 9) == 0);
        else step(pat(p), $urandom_range(0, 19) == 0);
        total++;
        if (dut_vec !== m_vec())
          $display("FAIL random s%0d k%0d: got %h expected %h", seg, k, dut_vec, m_vec());
        else passed++;
      end
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_nominal();
    test_conflict();
    test_skip();
    test_timing();
    test_code_clear();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
